// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU op codes, opcode/funct
// values, skid-buffer state and the stored entry. EX_OVF_EN adds the ovf field.
package ex_pkg;

    // Widest tag the entry struct can carry; ex_stage zero-extends into it.
    localparam int TAG_MAX_W = 16;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_e;

    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} bsel_e;

    typedef struct packed {
        logic [31:0]          result;
        logic                 zero;
        logic                 taken;
        logic [31:0]          target;
        logic [31:0]          store;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
`ifdef EX_OVF_EN
        logic                 ovf;
`endif
    } entry_t;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
    } alu_out_t;

    // op[2] inverts b and injects the carry, so sub/slt share the adder with add.
    function automatic alu_out_t alu(input logic [2:0] op,
                                     input logic signed [31:0] a,
                                     input logic signed [31:0] b);
        alu_out_t    r;
        logic [31:0] b_eff;
        logic [31:0] sum;
        logic        lt;
        b_eff = op[2] ? ~b : b;
        sum   = a + b_eff + {31'b0, op[2]};
        lt    = (a[31] ^ b[31]) ? a[31] : sum[31];
        r     = '0;
        unique case (op[1:0])
            2'b00: r.y = a & b;
            2'b01: r.y = a | b;
            2'b10: r.y = sum;
            default: r.y = {31'b0, lt};
        endcase
        r.ovf = (op[1:0] == 2'b10) && (a[31] == b_eff[31]) && (sum[31] != a[31]);
        return r;
    endfunction

endpackage

// File: rtl/ex_decode.sv
// Combinational decode of opcode/funct into ALU op, second-operand select,
// branch flag and illegal-instruction flag.
module ex_decode
    import ex_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output bsel_e      b_sel,
    output logic       is_beq,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        b_sel   = B_RT;
        is_beq  = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_op = ALU_ADD;
                b_sel  = B_SEXT;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                b_sel  = B_ZEXT;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                b_sel  = B_ZEXT;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                is_beq = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decode, ALU and branch target feeding a two-entry skid buffer.
// Define EX_OVF_EN to add the out_ovf port and per-entry overflow storage.
module ex_stage
    import ex_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [15:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_taken,
    output logic [31:0]      out_target,
    output logic [31:0]      out_store,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef EX_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // Stage p0: decode, operand select, ALU and branch target (combinational)
    logic [2:0]         alu_op_p0;
    bsel_e              b_sel_p0;
    logic               is_beq_p0;
    logic               illegal_p0;
    logic signed [31:0] a_p0;
    logic signed [31:0] b_p0;
    alu_out_t           alu_p0;
    entry_t             new_p0;

    ex_decode u_decode (
        .opcode  (in_opcode),
        .funct   (in_funct),
        .alu_op  (alu_op_p0),
        .b_sel   (b_sel_p0),
        .is_beq  (is_beq_p0),
        .illegal (illegal_p0)
    );

    always_comb begin
        a_p0 = in_rs;
        unique case (b_sel_p0)
            B_SEXT:  b_p0 = {{16{in_imm[15]}}, in_imm};
            B_ZEXT:  b_p0 = {16'b0, in_imm};
            default: b_p0 = in_rt;
        endcase
        alu_p0 = alu(alu_op_p0, a_p0, b_p0);
    end

    always_comb begin
        new_p0         = '0;
        new_p0.illegal = illegal_p0;
        new_p0.result  = illegal_p0 ? 32'b0 : alu_p0.y;
        new_p0.zero    = illegal_p0 | (alu_p0.y == 32'b0);
        new_p0.taken   = is_beq_p0 & ~illegal_p0 & (alu_p0.y == 32'b0);
        new_p0.target  = in_pc + 32'd4 + {{14{in_imm[15]}}, in_imm, 2'b00};
        new_p0.store   = in_rt;
        new_p0.tag     = TAG_MAX_W'(in_tag);
`ifdef EX_OVF_EN
        new_p0.ovf     = alu_p0.ovf & ~illegal_p0;
`endif
    end

    // Stage p1: two-entry skid buffer (head drives out_*, skid holds the second)
    skid_state_e state;
    skid_state_e state_nx;
    entry_t      head_p1;
    entry_t      skid_p1;
    entry_t      head_out;
    logic        accept;
    logic        drain;
    logic        load_head_new;
    logic        load_head_skid;
    logic        load_skid;

    assign in_ready  = (state != SKID_FULL);
    assign out_valid = (state != SKID_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= SKID_EMPTY;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    state_nx      = SKID_ONE;
                    load_head_new = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_nx  = SKID_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nx = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (drain) begin
                    state_nx       = SKID_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nx = SKID_EMPTY;
        endcase
    end

    // Entry storage is never reset: the state alone decides what is live.
    always_ff @(posedge clk) begin
        if (load_head_new)       head_p1 <= new_p0;
        else if (load_head_skid) head_p1 <= skid_p1;
        if (load_skid)           skid_p1 <= new_p0;
    end

    // Outputs read as zero whenever nothing is held, including right after reset.
    assign head_out    = out_valid ? head_p1 : '0;
    assign out_result  = head_out.result;
    assign out_zero    = head_out.zero;
    assign out_taken   = head_out.taken;
    assign out_target  = head_out.target;
    assign out_store   = head_out.store;
    assign out_illegal = head_out.illegal;
    assign out_tag     = head_out.tag[TAG_W-1:0];

    logic lint_unused;
`ifdef EX_OVF_EN
    assign out_ovf     = head_out.ovf;
    assign lint_unused = ^head_out.tag;
`else
    assign lint_unused = ^{head_out.tag, alu_p0.ovf};
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push hand-computed
// expectations; a monitor pops and compares on every output transfer.
module tb_ex_stage;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [5:0]       in_funct;
    logic [31:0]      in_rs;
    logic [31:0]      in_rt;
    logic [15:0]      in_imm;
    logic [31:0]      in_pc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_taken;
    logic [31:0]      out_target;
    logic [31:0]      out_store;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
`ifdef EX_OVF_EN
    logic             out_ovf;
`endif

    always #5 clk = ~clk;

    ex_stage #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct    (in_funct),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_taken   (out_taken),
        .out_target  (out_target),
        .out_store   (out_store),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
`ifdef EX_OVF_EN
        ,
        .out_ovf     (out_ovf)
`endif
    );

    typedef struct {
        logic [31:0]      result;
        logic             zero;
        logic             taken;
        logic [31:0]      target;
        logic [31:0]      store;
        logic             illegal;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    int               compared   = 0;
    int               mismatched = 0;
    logic [TAG_W-1:0] tag_ctr    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready.
    exp_t e_mon;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got tag %0d, expected no output", out_tag);
                end else begin
                    e_mon = sb.pop_front();
                    chk("result",  out_result,           e_mon.result);
                    chk("zero",    32'(out_zero),        32'(e_mon.zero));
                    chk("taken",   32'(out_taken),       32'(e_mon.taken));
                    chk("target",  out_target,           e_mon.target);
                    chk("store",   out_store,            e_mon.store);
                    chk("illegal", 32'(out_illegal),     32'(e_mon.illegal));
                    chk("tag",     32'(out_tag),         32'(e_mon.tag));
`ifdef EX_OVF_EN
                    chk("ovf",     32'(out_ovf),         32'(e_mon.ovf));
`endif
                end
            end
        end
    end

    // Offer one instruction (called at posedge+1), return at posedge+1 after accept.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [31:0] pc,
                         input logic [31:0] r, input logic z, input logic t,
                         input logic [31:0] tgt, input logic ill, input logic ovf);
        exp_t e;
        int   waited;
        in_valid  = 1'b1;
        in_opcode = op;
        in_funct  = fn;
        in_rs     = rs;
        in_rt     = rt;
        in_imm    = imm;
        in_pc     = pc;
        in_tag    = tag_ctr;
        e = '{r, z, t, tgt, rt, ill, tag_ctr, ovf};
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        tag_ctr++;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        int waited;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_funct  = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_imm    = '0;
        in_pc     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid),  32'd0);
        chk("reset_in_ready",  32'(in_ready),   32'd1);
        chk("reset_result",    out_result,      32'd0);
        chk("reset_zero",      32'(out_zero),   32'd0);
        reset = 1'b0;

        // add 5+7, with one-cycle latency check
        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 32'h0, 32'd12, 0, 0, 32'h4, 0, 0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        // back-to-back stream at full throughput
        issue(6'h04, 6'h00, 32'h1234, 32'h1234, 16'hFFFF, 32'h100, 32'h0, 1, 1, 32'h100, 0, 0);
        issue(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 16'h0000, 32'h200, 32'h1, 0, 0, 32'h204, 0, 0);
        issue(6'h0C, 6'h00, 32'hFFFF00FF, 32'h0, 16'h0F0F, 32'h300, 32'hF, 0, 0, 32'h3F40, 0, 0);
        issue(6'h00, 6'h22, 32'd10, 32'd3, 16'h0000, 32'h0, 32'd7, 0, 0, 32'h4, 0, 0);
        issue(6'h00, 6'h25, 32'hF0, 32'h0F, 16'h0000, 32'h0, 32'hFF, 0, 0, 32'h4, 0, 0);
        issue(6'h0D, 6'h00, 32'h12340000, 32'h0, 16'h8001, 32'h0, 32'h12348001, 0, 0, 32'hFFFE0008, 0, 0);
        issue(6'h08, 6'h00, 32'd100, 32'h0, 16'hFFFF, 32'h10, 32'd99, 0, 0, 32'h10, 0, 0);
        issue(6'h23, 6'h00, 32'h1000, 32'h0, 16'h0008, 32'h0, 32'h1008, 0, 0, 32'h24, 0, 0);
        issue(6'h04, 6'h00, 32'd1, 32'd2, 16'h0002, 32'h40, 32'hFFFFFFFF, 0, 0, 32'h4C, 0, 0);
        issue(6'h00, 6'h00, 32'd5, 32'd7, 16'h0000, 32'h0, 32'h0, 1, 0, 32'h4, 1, 0);
        issue(6'h2B, 6'h00, 32'h2000, 32'hDEADBEEF, 16'h0004, 32'h0, 32'h2004, 0, 0, 32'h14, 0, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // backpressure: two fill the buffer, the third waits
        out_ready = 1'b0;
        issue(6'h00, 6'h20, 32'd1, 32'd2, 16'h0000, 32'h0, 32'd3, 0, 0, 32'h4, 0, 0);
        issue(6'h00, 6'h20, 32'd3, 32'd4, 16'h0000, 32'h0, 32'd7, 0, 0, 32'h4, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b1;
        in_opcode = 6'h00;
        in_funct  = 6'h22;
        in_rs     = 32'd9;
        in_rt     = 32'd4;
        in_imm    = 16'h0;
        in_pc     = 32'h0;
        in_tag    = tag_ctr;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_in_ready",  32'(in_ready),  32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_result",    out_result,     32'd3);
        chk("stall_tag",       32'(out_tag),   32'(tag_ctr - 4'd2));
        out_ready = 1'b1;
        issue(6'h00, 6'h22, 32'd9, 32'd4, 16'h0000, 32'h0, 32'd5, 0, 0, 32'h4, 0, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // reset while full discards both entries
        out_ready = 1'b0;
        issue(6'h00, 6'h20, 32'd11, 32'd22, 16'h0000, 32'h0, 32'd33, 0, 0, 32'h4, 0, 0);
        issue(6'h00, 6'h20, 32'd44, 32'd55, 16'h0000, 32'h0, 32'd99, 0, 0, 32'h4, 0, 0);
        idle();
        chk("prereset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        chk("rst_full_out_valid", 32'(out_valid),  32'd0);
        chk("rst_full_in_ready",  32'(in_ready),   32'd1);
        chk("rst_full_result",    out_result,      32'd0);
        chk("rst_full_zero",      32'(out_zero),   32'd0);
        chk("rst_full_tag",       32'(out_tag),    32'd0);
        out_ready = 1'b1;
        issue(6'h3F, 6'h00, 32'h12345678, 32'h9, 16'h0000, 32'h0, 32'h0, 1, 0, 32'h4, 1, 0);

`ifdef EX_OVF_EN
        issue(6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0000, 32'h0, 32'h80000000, 0, 0, 32'h4, 0, 1);
        issue(6'h00, 6'h22, 32'h80000000, 32'h1, 16'h0000, 32'h0, 32'h7FFFFFFF, 0, 0, 32'h4, 0, 1);
        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 32'h0, 32'd12, 0, 0, 32'h4, 0, 0);
`endif
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
